// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer
// Drives the CSR file's single write port and single combinational read port.
// Trap entry (ECALL) and trap return (MRET) are performed as a fixed sequence
// of single-cycle steps ending in a PC redirect to the IFU. Ordinary CSR
// writes from EXU are passed through only while no trap sequence is running.
module csr_trap_sequencer #(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MTVEC_ADDR   = 12'h305,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
    input  logic                  clock,
    input  logic                  reset,
    // trap request from WBU
    input  logic                  trap_valid,
    output logic                  trap_ready,
    input  logic [1:0]            trap_type,
    input  logic [DATA_WIDTH-1:0] trap_pc,
    input  logic [DATA_WIDTH-1:0] trap_cause,
    // ordinary CSR write request from EXU
    input  logic                  csr_req_valid,
    output logic                  csr_req_ready,
    input  logic [11:0]           csr_req_addr,
    input  logic [DATA_WIDTH-1:0] csr_req_wdata,
    // CSR file ports
    output logic [11:0]           csr_raddr,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_wen,
    output logic [11:0]           csr_waddr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    // redirect to IFU
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  busy
);

    localparam logic [1:0] TYPE_ECALL = 2'b01;
    localparam logic [1:0] TYPE_MRET  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_R_MSTATUS,
        S_W_MSTATUS,
        S_R_TARGET,
        S_REDIRECT
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   cause_q, cause_d;
    logic                    ecall_q, ecall_d;      // 1: ECALL sequence, 0: MRET sequence
    logic [DATA_WIDTH-1:0]   ms_q, ms_d;            // mstatus snapshot read in R_MSTATUS
    logic [DATA_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;

    // New mstatus value: ECALL stacks MIE into MPIE and disables interrupts,
    // MRET restores MIE from MPIE and sets MPIE. MPP is always forced to M-mode.
    function automatic logic [DATA_WIDTH-1:0] mstatus_update(
        input logic [DATA_WIDTH-1:0] ms,
        input logic                  is_ecall
    );
        logic [DATA_WIDTH-1:0] r;
        r        = ms;
        r[12:11] = 2'b11;
        if (is_ecall) begin
            r[7] = ms[3];
            r[3] = 1'b0;
        end else begin
            r[3] = ms[7];
            r[7] = 1'b1;
        end
        return r;
    endfunction

    // State and captured-register update; reset abandons any running sequence.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            cause_q       <= '0;
            ecall_q       <= 1'b0;
            ms_q          <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cause_q       <= cause_d;
            ecall_q       <= ecall_d;
            ms_q          <= ms_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Next-state logic and all CSR/redirect port outputs, derived from the state.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        cause_d        = cause_q;
        ecall_d        = ecall_q;
        ms_d           = ms_q;
        redirect_pc_d  = redirect_pc_q;
        trap_ready     = 1'b0;
        csr_req_ready  = 1'b0;
        csr_raddr      = '0;
        csr_wen        = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        busy           = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy          = 1'b0;
                trap_ready    = 1'b1;
                csr_req_ready = !trap_valid;
                if (trap_valid) begin
                    // Reserved trap types are consumed here with no side effects.
                    pc_d    = trap_pc;
                    cause_d = trap_cause;
                    if (trap_type == TYPE_ECALL) begin
                        ecall_d = 1'b1;
                        state_d = S_W_MEPC;
                    end else if (trap_type == TYPE_MRET) begin
                        ecall_d = 1'b0;
                        state_d = S_R_MSTATUS;
                    end
                end else if (csr_req_valid) begin
                    csr_wen   = 1'b1;
                    csr_waddr = csr_req_addr;
                    csr_wdata = csr_req_wdata;
                end
            end
            S_W_MEPC: begin
                csr_wen   = 1'b1;
                csr_waddr = MEPC_ADDR;
                csr_wdata = pc_q;
                state_d   = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = MCAUSE_ADDR;
                csr_wdata = cause_q;
                state_d   = S_R_MSTATUS;
            end
            S_R_MSTATUS: begin
                csr_raddr = MSTATUS_ADDR;
                ms_d      = csr_rdata;
                state_d   = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                csr_wen   = 1'b1;
                csr_waddr = MSTATUS_ADDR;
                csr_wdata = mstatus_update(ms_q, ecall_q);
                state_d   = S_R_TARGET;
            end
            S_R_TARGET: begin
                // ECALL supports direct-mode mtvec only, so the mode bits are dropped.
                if (ecall_q) begin
                    csr_raddr     = MTVEC_ADDR;
                    redirect_pc_d = {csr_rdata[DATA_WIDTH-1:2], 2'b00};
                end else begin
                    csr_raddr     = MEPC_ADDR;
                    redirect_pc_d = csr_rdata;
                end
                state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign redirect_pc = redirect_pc_q;

endmodule
